cpu_seq_ctrl: RTL

Instruction sequencer for the tiny 8-bit CPU. It divides the 12 MHz `CLK` into an instruction-rate tick and steps each instruction through FETCH → DECODE → EXEC → WB. In WB it pulses the register-file write enable and the PC increment. It also provides run, single-step, halt-on-HLT and resume control for the LED demo, and sits between the ROM/PC/register file and the board-level buttons.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/tick_gen.sv | 27 ++
 rtl/cpu_seq_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the tiny 8-bit CPU sequencer: opcode constants and
// the instruction-step state encoding.
package cpu_pkg;

    localparam int OP_WIDTH = 4;

    localparam logic [OP_WIDTH-1:0] OP_NOP = 4'h0;
    localparam logic [OP_WIDTH-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high for the one cycle in which the count
// reaches PRESCALE-1. PRESCALE=1 gives a tick every cycle.
module tick_gen #(
    parameter int PRESCALE = 1200000
) (
    input  logic CLK,
    input  logic RST_N,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Instruction sequencer: steps each instruction FETCH->DECODE->EXEC->WB on the
// prescaled tick, with single-step queueing, halt-on-HLT and resume.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int PRESCALE = 1200000,
    parameter int OP_W     = OP_WIDTH,
    parameter int CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             run,
    input  logic             step,
    input  logic             resume,
    input  logic [OP_W-1:0]  opcode,
    output logic             ir_load,
    output logic             alu_en,
    output logic             rf_we,
    output logic             pc_inc,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [OP_W-1:0] NOP = OP_W'(OP_NOP);
    localparam logic [OP_W-1:0] HLT = OP_W'(OP_HLT);

    state_t state, state_n;
    logic   tick, step_pend;
    logic   ir_load_n, alu_en_n, rf_we_n, pc_inc_n, busy_n, halted_n;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .tick  (tick)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Outputs are decoded from the next state and registered, so each one is
    // a flop aligned with the state it belongs to.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if ((run && tick) || step || step_pend) state_n = FETCH;
            FETCH:   state_n = DECODE;
            DECODE:  state_n = (opcode == HLT) ? HALT : EXEC;
            EXEC:    state_n = WB;
            WB:      state_n = IDLE;
            HALT:    if (resume) state_n = WB;
            default: state_n = IDLE;
        endcase

        ir_load_n = (state_n == FETCH);
        alu_en_n  = (state_n == EXEC);
        pc_inc_n  = (state_n == WB);
        // Resume reuses WB for pc_inc/retire but must never write the RF.
        rf_we_n   = (state_n == WB) && (state == EXEC) && (opcode != NOP);
        busy_n    = (state_n != IDLE) && (state_n != HALT);
        halted_n  = (state_n == HALT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ir_load <= 1'b0;
            alu_en  <= 1'b0;
            rf_we   <= 1'b0;
            pc_inc  <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            ir_load <= ir_load_n;
            alu_en  <= alu_en_n;
            rf_we   <= rf_we_n;
            pc_inc  <= pc_inc_n;
            busy    <= busy_n;
            halted  <= halted_n;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            step_pend <= 1'b0;
        else if (state_n == FETCH)
            step_pend <= 1'b0;
        else if (step && (state != IDLE) && (state != HALT))
            step_pend <= 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            retired <= '0;
        else if (state == WB)
            retired <= retired + 1'b1;
    end

endmodule
